stereo_sync_ctrl: RTL and testbench
===================================

STEREO_SYNC_CTRL -- requirements
Module: stereo_sync_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 4: number of cycles camera resets are held high per reset request (1..255).
REQ-002 Parameter TIMEOUT, default 1000000: cycles allowed in WAIT_FRAME before re-reset (1..2^20-1).
REQ-003 clock  in  1  single system clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous active-low reset: assertion acts immediately, release is sampled on clock.
REQ-005 cam_lreset, cam_rreset  out  1 each  active-high resets to the left and right camera models.
REQ-006 loGray, roGray  in  10 each  camera pixel data; llineClock, rlineClock, lframeClock, rframeClock  in  1 each  active-high line-valid and frame-valid levels.
REQ-007 l_pix, r_pix  out  10 each  registered pixel pair; pix_valid  out  1  pair qualifier.
REQ-008 col, row  out  10 each  pixel coordinates of the current pair.
REQ-009 frame_start  out  1  one-cycle pulse with the first pair of a frame.
REQ-010 locked  out  1  high while in STREAM; timeout_err  out  1  sticky; resync_count  out  8  saturating mismatch count.

Function
REQ-011 States: RESET_CAMS, WAIT_FRAME, STREAM, RESYNC; encoding is implementation choice.
REQ-012 RESET_CAMS: cam_lreset = cam_rreset = 1 for exactly RST_CYCLES cycles, then WAIT_FRAME; both resets drop in the same cycle.
REQ-013 Edge detection uses one register stage per frame input; a rise is prev=0 and cur=1.
REQ-014 WAIT_FRAME: both frameClocks rise in the same cycle -> STREAM; only one rises -> RESYNC; neither for TIMEOUT cycles -> set timeout_err, go RESET_CAMS.
REQ-015 Timeout counter clears on every entry to WAIT_FRAME.
REQ-016 STREAM: any cycle with llineClock != rlineClock or lframeClock != rframeClock -> RESYNC next cycle; locked drops the same cycle RESYNC is entered.
REQ-017 RESYNC: lasts one cycle, increments resync_count (saturate at 255), then RESET_CAMS.
REQ-018 pix_valid = 1 exactly one cycle after a STREAM cycle with both lineClocks and both frameClocks high; l_pix/r_pix carry that cycle's loGray/roGray.
REQ-019 l_pix, r_pix hold their last value when pix_valid = 0.
REQ-020 col = 0 on the first valid pair of a line; +1 per valid pair; saturates at 1023.
REQ-021 row = 0 on the first line of a frame; +1 on each falling edge of llineClock in STREAM; saturates at 1023.
REQ-022 frame_start = 1 with the pair where row = 0 and col = 0; otherwise 0.
REQ-023 Mismatch in the same cycle as a valid pair: the pair is not emitted (pix_valid stays 0).
REQ-024 Inputs are sampled raw; cameras share clock, so no synchronizers are required.

Reset
REQ-025 While reset = 0: state RESET_CAMS with cycle counter 0, cam_lreset = cam_rreset = 1, pix_valid = 0, frame_start = 0, locked = 0, l_pix = r_pix = 0, col = row = 0, resync_count = 0, timeout_err = 0, edge registers 0.
REQ-026 After release the full RST_CYCLES camera-reset sequence runs before any frame is accepted.
REQ-027 Reset mid-frame discards all in-flight state; no partial pair is emitted afterwards.

Verification
REQ-028 Release reset, both cameras start identically (same file) -> cam resets high 4 cycles, locked rises one cycle after simultaneous frame rise, first pair: frame_start = 1, col = 0, row = 0.
REQ-029 Line of 256 pixels from both -> 256 pix_valid pulses, col 0..255, row +1 after the line falls.
REQ-030 Right frameClock delayed 1 cycle in WAIT_FRAME -> RESYNC, resync_count = 1, cam resets reasserted 4 cycles.
REQ-031 In STREAM force rlineClock low for one cycle mid-line -> pair suppressed that cycle, locked = 0 next cycle, resync_count increments.
REQ-032 TIMEOUT = 50, no frameClock ever rises -> timeout_err = 1 after 50 WAIT_FRAME cycles, cam resets reissued, timeout_err stays 1.
REQ-033 Assert reset for 1 cycle mid-line, then release -> all outputs at REQ-025 values, sequence restarts from RESET_CAMS, resync_count = 0.

Source files
------------

// File: rtl/stereo_sync_ctrl.sv
// Stereo camera sync controller: resets both cameras, waits for a common frame
// start, streams coordinated pixel pairs and forces a resync on any mismatch.
module stereo_sync_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1000000,
  parameter int DATA_W     = 10
) (
  input  logic              clock,
  input  logic              reset,
  output logic              cam_lreset,
  output logic              cam_rreset,
  input  logic [DATA_W-1:0] loGray,
  input  logic [DATA_W-1:0] roGray,
  input  logic              llineClock,
  input  logic              rlineClock,
  input  logic              lframeClock,
  input  logic              rframeClock,
  output logic [DATA_W-1:0] l_pix,
  output logic [DATA_W-1:0] r_pix,
  output logic              pix_valid,
  output logic [9:0]        col,
  output logic [9:0]        row,
  output logic              frame_start,
  output logic              locked,
  output logic              timeout_err,
  output logic [7:0]        resync_count
);

  typedef enum logic [1:0] {
    S_RESET_CAMS,
    S_WAIT_FRAME,
    S_STREAM,
    S_RESYNC
  } state_t;

  localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  rst_cnt;
  logic [19:0] to_cnt;
  logic        lframe_p1;
  logic        rframe_p1;
  logic        lline_p1;
  logic        line_first;
  logic        l_rise;
  logic        r_rise;
  logic        l_fall;
  logic        mismatch;
  logic        pair_ok;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign l_rise   = lframeClock & ~lframe_p1;
  assign r_rise   = rframeClock & ~rframe_p1;
  assign l_fall   = ~llineClock & lline_p1;
  assign mismatch = (llineClock != rlineClock) | (lframeClock != rframeClock);
  assign pair_ok  = (state == S_STREAM) & llineClock & rlineClock &
                    lframeClock & rframeClock;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_RESET_CAMS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET_CAMS: if (rst_cnt == RST_LAST) state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (l_rise && r_rise)       state_nxt = S_STREAM;
        else if (l_rise || r_rise)  state_nxt = S_RESYNC;
        else if (to_cnt == TO_LAST) state_nxt = S_RESET_CAMS;
      end
      S_STREAM:     if (mismatch) state_nxt = S_RESYNC;
      S_RESYNC:     state_nxt = S_RESET_CAMS;
      default:      state_nxt = S_RESET_CAMS;
    endcase
  end

  always_comb begin
    cam_lreset = (state == S_RESET_CAMS);
    cam_rreset = (state == S_RESET_CAMS);
    locked     = (state == S_STREAM);
  end

  // p1: one-cycle history of frame/line levels plus sequencing counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lframe_p1    <= 1'b0;
      rframe_p1    <= 1'b0;
      lline_p1     <= 1'b0;
      rst_cnt      <= 8'd0;
      to_cnt       <= 20'd0;
      timeout_err  <= 1'b0;
      resync_count <= 8'd0;
    end else begin
      lframe_p1 <= lframeClock;
      rframe_p1 <= rframeClock;
      lline_p1  <= llineClock;
      rst_cnt   <= (state == S_RESET_CAMS && rst_cnt != RST_LAST) ? rst_cnt + 8'd1 : 8'd0;
      to_cnt    <= (state == S_WAIT_FRAME) ? to_cnt + 20'd1 : 20'd0;
      // Sticky: only a full reset clears a timeout indication
      if (state == S_WAIT_FRAME && state_nxt == S_RESET_CAMS) timeout_err <= 1'b1;
      if (state == S_RESYNC) resync_count <= sat_inc8(resync_count);
    end
  end

  // p1: registered pixel pair and its coordinates
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      l_pix       <= '0;
      r_pix       <= '0;
      col         <= 10'd0;
      row         <= 10'd0;
      line_first  <= 1'b0;
    end else begin
      pix_valid   <= pair_ok;
      frame_start <= pair_ok & line_first & (row == 10'd0);
      if (pair_ok) begin
        l_pix      <= loGray;
        r_pix      <= roGray;
        col        <= line_first ? 10'd0 : sat_inc10(col);
        line_first <= 1'b0;
      end
      if (state == S_WAIT_FRAME && state_nxt == S_STREAM) begin
        row        <= 10'd0;
        line_first <= 1'b1;
      end else if (state == S_STREAM && l_fall) begin
        row        <= sat_inc10(row);
        line_first <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stereo_sync_ctrl.sv
// Bench for stereo_sync_ctrl: per-cycle behavioural model comparison plus
// directed scenarios with hand-computed expectations.
module tb_stereo_sync_ctrl;
  localparam int RST = 4;
  localparam int TO  = 50;
  localparam int M_CAMS = 0, M_WAIT = 1, M_STREAM = 2, M_RESYNC = 3;

  logic       clock;
  logic       reset;
  logic       cam_lreset, cam_rreset;
  logic [9:0] loGray, roGray;
  logic       llineClock, rlineClock, lframeClock, rframeClock;
  logic [9:0] l_pix, r_pix;
  logic       pix_valid;
  logic [9:0] col, row;
  logic       frame_start, locked, timeout_err;
  logic [7:0] resync_count;

  int checks = 0;
  int failures = 0;

  stereo_sync_ctrl #(.RST_CYCLES(RST), .TIMEOUT(TO), .DATA_W(10)) dut (
    .clock(clock), .reset(reset),
    .cam_lreset(cam_lreset), .cam_rreset(cam_rreset),
    .loGray(loGray), .roGray(roGray),
    .llineClock(llineClock), .rlineClock(rlineClock),
    .lframeClock(lframeClock), .rframeClock(rframeClock),
    .l_pix(l_pix), .r_pix(r_pix), .pix_valid(pix_valid),
    .col(col), .row(row), .frame_start(frame_start),
    .locked(locked), .timeout_err(timeout_err), .resync_count(resync_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode plus countdown/age counters derived from the rules
  int         m_mode, m_cams_left, m_wait_age, m_row, m_col, m_resync;
  bit         m_newline, m_timeout, m_pv, m_fs, lf_q, rf_q, ll_q;
  bit         m_lrise, m_rrise, m_lfall, m_allhi;
  logic [9:0] m_lpix, m_rpix;

  task automatic model_init();
    m_mode = M_CAMS; m_cams_left = RST; m_wait_age = 0;
    m_row = 0; m_col = 0; m_resync = 0; m_newline = 0; m_timeout = 0;
    m_pv = 0; m_fs = 0; lf_q = 0; rf_q = 0; ll_q = 0; m_lpix = 0; m_rpix = 0;
  endtask

  task automatic model_step();
    m_lrise = lframeClock && !lf_q;
    m_rrise = rframeClock && !rf_q;
    m_lfall = !llineClock && ll_q;
    m_allhi = llineClock && rlineClock && lframeClock && rframeClock;
    if (m_mode == M_STREAM && m_allhi) begin
      m_pv = 1;
      m_fs = (m_row == 0) && m_newline;
      m_col = m_newline ? 0 : ((m_col < 1023) ? m_col + 1 : 1023);
      m_newline = 0;
      m_lpix = loGray;
      m_rpix = roGray;
    end else begin
      m_pv = 0;
      m_fs = 0;
    end
    if (m_mode == M_STREAM && m_lfall) begin
      m_row = (m_row < 1023) ? m_row + 1 : 1023;
      m_newline = 1;
    end
    case (m_mode)
      M_CAMS: begin
        m_cams_left--;
        if (m_cams_left == 0) begin m_mode = M_WAIT; m_wait_age = 0; end
      end
      M_WAIT: begin
        m_wait_age++;
        if (m_lrise && m_rrise) begin m_mode = M_STREAM; m_row = 0; m_newline = 1; end
        else if (m_lrise != m_rrise) m_mode = M_RESYNC;
        else if (m_wait_age == TO) begin m_timeout = 1; m_mode = M_CAMS; m_cams_left = RST; end
      end
      M_STREAM: if (llineClock != rlineClock || lframeClock != rframeClock) m_mode = M_RESYNC;
      default: begin
        m_resync = (m_resync < 255) ? m_resync + 1 : 255;
        m_mode = M_CAMS;
        m_cams_left = RST;
      end
    endcase
    lf_q = lframeClock; rf_q = rframeClock; ll_q = llineClock;
  endtask

  always @(negedge clock) begin
    if (!reset) model_init();
    chk("cyc_cam_lreset", cam_lreset, m_mode == M_CAMS);
    chk("cyc_cam_rreset", cam_rreset, m_mode == M_CAMS);
    chk("cyc_locked", locked, m_mode == M_STREAM);
    chk("cyc_pix_valid", pix_valid, m_pv);
    chk("cyc_frame_start", frame_start, m_fs);
    chk("cyc_l_pix", l_pix, m_lpix);
    chk("cyc_r_pix", r_pix, m_rpix);
    chk("cyc_col", col, m_col);
    chk("cyc_row", row, m_row);
    chk("cyc_timeout_err", timeout_err, m_timeout);
    chk("cyc_resync_count", resync_count, m_resync);
    if (reset) model_step();
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    llineClock = 0; rlineClock = 0; lframeClock = 0; rframeClock = 0;
    loGray = 0; roGray = 0;
  endtask

  task automatic count_cam_reset(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (cam_lreset) n++;
      else if (n > 0) return;
      tick();
    end
  endtask

  task automatic start_frame();
    lframeClock = 1; rframeClock = 1;
    tick();
    chk("lock_after_rise", locked, 1);
  endtask

  task automatic send_line(input int n, input int base, input int glitch, input bit first_line);
    logic [9:0] v;
    logic [9:0] rv;
    for (int i = 0; i < n; i++) begin
      v = 10'(base + i);
      rv = ~v;
      llineClock = 1; rlineClock = (i != glitch); loGray = v; roGray = rv;
      tick();
      if (i == glitch) begin
        chk("glitch_pix_valid", pix_valid, 0);
        chk("glitch_locked", locked, 0);
        break;
      end
      chk("line_pix_valid", pix_valid, 1);
      chk("line_col", col, (i < 1023) ? i : 1023);
      chk("line_l_pix", l_pix, v);
      chk("line_r_pix", r_pix, rv);
      if (first_line) chk("line_frame_start", frame_start, i == 0);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cam_lreset"}, cam_lreset, 1);
    chk({tag, "_cam_rreset"}, cam_rreset, 1);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_l_pix"}, l_pix, 0);
    chk({tag, "_r_pix"}, r_pix, 0);
    chk({tag, "_col"}, col, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_resync"}, resync_count, 0);
    chk({tag, "_timeout"}, timeout_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 0;
    idle_inputs();
    repeat (3) tick();
    chk_reset_values("rst");
    reset = 1;

    // Power-up: reset sequence, simultaneous frame rise, one 256-pixel line
    count_cam_reset(n);
    chk("powerup_cam_reset_cycles", n, 4);
    chk("wait_not_locked", locked, 0);
    start_frame();
    tick();
    send_line(256, 0, -1, 1);
    llineClock = 0; rlineClock = 0;
    tick();
    chk("eol_pix_valid", pix_valid, 0);
    chk("eol_row", row, 1);
    chk("eol_col", col, 255);

    // Right line drops for one cycle mid-line
    send_line(20, 100, 7, 0);
    idle_inputs();
    tick();
    chk("glitch_resync_count", resync_count, 1);
    chk("glitch_cam_reset", cam_lreset, 1);
    count_cam_reset(n);
    chk("glitch_cam_reset_cycles", n, 4);

    // Right frame rises one cycle after the left
    lframeClock = 1;
    tick();
    chk("late_r_resync_state", cam_lreset, 0);
    chk("late_r_locked", locked, 0);
    rframeClock = 1;
    tick();
    chk("late_r_resync_count", resync_count, 2);
    chk("late_r_cam_reset", cam_lreset, 1);
    idle_inputs();
    count_cam_reset(n);
    chk("late_r_cam_reset_cycles", n, 4);

    // No frame at all: timeout after TO wait cycles
    n = 0;
    while (!cam_lreset && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_wait_cycles", n, 50);
    chk("timeout_err_set", timeout_err, 1);
    count_cam_reset(n);
    chk("timeout_cam_reset_cycles", n, 4);
    chk("timeout_err_sticky", timeout_err, 1);

    // Column and row saturation
    start_frame();
    tick();
    send_line(1030, 5, -1, 0);
    llineClock = 0; rlineClock = 0;
    tick();
    for (int k = 0; k < 1030; k++) begin
      send_line(1, k, -1, 0);
      llineClock = 0; rlineClock = 0;
      tick();
    end
    chk("row_saturated", row, 1023);
    chk("timeout_err_still", timeout_err, 1);
    rframeClock = 1; lframeClock = 0;
    tick();
    rframeClock = 1; lframeClock = 1;
    tick();
    rframeClock = 0; lframeClock = 0;
    tick();
    chk("frame_mismatch_resync", resync_count, 3);
    count_cam_reset(n);

    // Resync counter saturation
    for (int k = 0; k < 260; k++) begin
      lframeClock = 1;
      tick();
      lframeClock = 0;
      tick();
      count_cam_reset(n);
    end
    chk("resync_saturated", resync_count, 255);

    // Reset pulse mid-line
    start_frame();
    llineClock = 1; rlineClock = 1; loGray = 10'd77; roGray = 10'd88;
    repeat (3) tick();
    reset = 0;
    #1;
    chk_reset_values("midrst");
    tick();
    reset = 1;
    chk("midrst_release_pix_valid", pix_valid, 0);
    count_cam_reset(n);
    chk("midrst_cam_reset_cycles", n, 4);
    chk("midrst_resync_zero", resync_count, 0);
    chk("midrst_timeout_zero", timeout_err, 0);
    idle_inputs();
    tick();
    start_frame();
    tick();
    send_line(4, 300, -1, 1);
    idle_inputs();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
